// File: rtl/sine_generator.sv
// Sine-wave PWM generator.
// A 64-entry sine table is stepped once per 256-clock PWM frame. The current
// sample sets the PWM duty cycle for the whole frame.
module sine_generator #(
    parameter int STEP = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pwm,
    output logic [7:0] sin_reg,
    output logic [7:0] update_c
);

    // Index increment per frame, reduced to the 6-bit table address width.
    localparam logic [5:0] STEP_INC = 6'(STEP);

    logic [5:0] idx;
    logic [5:0] idx_next;

    // One full sine period: round(128 + 127*sin(2*pi*i/64)).
    function automatic logic [7:0] sine_lut(input logic [5:0] i);
        logic [7:0] v;
        case (i)
            6'd0:  v = 8'd128;  6'd1:  v = 8'd140;  6'd2:  v = 8'd153;  6'd3:  v = 8'd165;
            6'd4:  v = 8'd177;  6'd5:  v = 8'd188;  6'd6:  v = 8'd199;  6'd7:  v = 8'd209;
            6'd8:  v = 8'd218;  6'd9:  v = 8'd226;  6'd10: v = 8'd234;  6'd11: v = 8'd240;
            6'd12: v = 8'd245;  6'd13: v = 8'd250;  6'd14: v = 8'd253;  6'd15: v = 8'd254;
            6'd16: v = 8'd255;  6'd17: v = 8'd254;  6'd18: v = 8'd253;  6'd19: v = 8'd250;
            6'd20: v = 8'd245;  6'd21: v = 8'd240;  6'd22: v = 8'd234;  6'd23: v = 8'd226;
            6'd24: v = 8'd218;  6'd25: v = 8'd209;  6'd26: v = 8'd199;  6'd27: v = 8'd188;
            6'd28: v = 8'd177;  6'd29: v = 8'd165;  6'd30: v = 8'd153;  6'd31: v = 8'd140;
            6'd32: v = 8'd128;  6'd33: v = 8'd116;  6'd34: v = 8'd103;  6'd35: v = 8'd91;
            6'd36: v = 8'd79;   6'd37: v = 8'd68;   6'd38: v = 8'd57;   6'd39: v = 8'd47;
            6'd40: v = 8'd38;   6'd41: v = 8'd30;   6'd42: v = 8'd22;   6'd43: v = 8'd16;
            6'd44: v = 8'd11;   6'd45: v = 8'd6;    6'd46: v = 8'd3;    6'd47: v = 8'd2;
            6'd48: v = 8'd1;    6'd49: v = 8'd2;    6'd50: v = 8'd3;    6'd51: v = 8'd6;
            6'd52: v = 8'd11;   6'd53: v = 8'd16;   6'd54: v = 8'd22;   6'd55: v = 8'd30;
            6'd56: v = 8'd38;   6'd57: v = 8'd47;   6'd58: v = 8'd57;   6'd59: v = 8'd68;
            6'd60: v = 8'd79;   6'd61: v = 8'd91;   6'd62: v = 8'd103;  6'd63: v = 8'd116;
            default: v = 8'd128;
        endcase
        return v;
    endfunction

    // 6-bit addition wraps naturally modulo 64.
    assign idx_next = idx + STEP_INC;

    // Frame counter free-runs; at frame end the index and sample advance together.
    always_ff @(posedge clk) begin
        if (reset) begin
            update_c <= 8'd0;
            idx      <= 6'd0;
            sin_reg  <= 8'd128;
        end else begin
            update_c <= update_c + 8'd1;
            if (update_c == 8'd255) begin
                idx     <= idx_next;
                sin_reg <= sine_lut(idx_next);
            end
        end
    end

    // PWM is high for the first sin_reg clocks of every frame.
    assign pwm = (update_c < sin_reg);

endmodule

// File: tb/tb_sine_generator.sv
// Directed bench for sine_generator: one instance with STEP=1, one with STEP=4,
// sharing clock and reset.
module tb_sine_generator;

    logic       clk;
    logic       reset;
    logic       pwm1;
    logic [7:0] sin1;
    logic [7:0] cnt1;
    logic       pwm4;
    logic [7:0] sin4;
    logic [7:0] cnt4;

    int total = 0;
    int bad   = 0;

    sine_generator #(.STEP(1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .pwm      (pwm1),
        .sin_reg  (sin1),
        .update_c (cnt1)
    );

    sine_generator #(.STEP(4)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .pwm      (pwm4),
        .sin_reg  (sin4),
        .update_c (cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, leaving the bench 1 time unit after the last edge.
    task automatic run_clocks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Single reset edge, then release.
    task automatic do_reset();
        reset = 1'b1;
        run_clocks(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run_clocks(3);
        total++; if (cnt1 !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt1); end
        total++; if (sin1 !== 8'd128) begin bad++; $display("FAIL reset_sin got=%0d exp=128", sin1); end
        total++; if (pwm1 !== 1'b1) begin bad++; $display("FAIL reset_pwm got=%b exp=1", pwm1); end
        total++; if (sin4 !== 8'd128) begin bad++; $display("FAIL reset_sin4 got=%0d exp=128", sin4); end
        // Reset held: counter must not advance.
        run_clocks(1);
        total++; if (cnt1 !== 8'd0) begin bad++; $display("FAIL reset_hold_cnt got=%0d exp=0", cnt1); end
        reset = 1'b0;
    endtask

    task automatic test_first_frame();
        int highs = 0;
        for (int i = 0; i < 256; i++) begin
            total++; if (cnt1 !== 8'(i)) begin bad++; $display("FAIL ff_cnt got=%0d exp=%0d", cnt1, i); end
            total++; if (pwm1 !== (i < 128)) begin bad++; $display("FAIL ff_pwm at=%0d got=%b exp=%b", i, pwm1, (i < 128)); end
            total++; if (sin1 !== 8'd128) begin bad++; $display("FAIL ff_hold at=%0d got=%0d exp=128", i, sin1); end
            if (pwm1 === 1'b1) highs++;
            run_clocks(1);
        end
        total++; if (highs != 128) begin bad++; $display("FAIL ff_highs got=%0d exp=128", highs); end
        total++; if (sin1 !== 8'd140) begin bad++; $display("FAIL ff_next_sin got=%0d exp=140", sin1); end
        total++; if (cnt1 !== 8'd0) begin bad++; $display("FAIL ff_wrap_cnt got=%0d exp=0", cnt1); end
        total++; if (sin4 !== 8'd177) begin bad++; $display("FAIL ff_step4 got=%0d exp=177", sin4); end
    endtask

    task automatic test_peak();
        int highs = 0;
        do_reset();
        run_clocks(16 * 256);
        total++; if (sin1 !== 8'd255) begin bad++; $display("FAIL peak_sin got=%0d exp=255", sin1); end
        for (int i = 0; i < 256; i++) begin
            total++; if (pwm1 !== (i != 255)) begin bad++; $display("FAIL peak_pwm at=%0d got=%b exp=%b", i, pwm1, (i != 255)); end
            if (pwm1 === 1'b1) highs++;
            run_clocks(1);
        end
        total++; if (highs != 255) begin bad++; $display("FAIL peak_highs got=%0d exp=255", highs); end
    endtask

    task automatic test_trough();
        do_reset();
        run_clocks(48 * 256);
        total++; if (sin1 !== 8'd1) begin bad++; $display("FAIL trough_sin got=%0d exp=1", sin1); end
        for (int i = 0; i < 256; i++) begin
            total++; if (pwm1 !== (i == 0)) begin bad++; $display("FAIL trough_pwm at=%0d got=%b exp=%b", i, pwm1, (i == 0)); end
            run_clocks(1);
        end
        total++; if (sin1 !== 8'd2) begin bad++; $display("FAIL trough_next got=%0d exp=2", sin1); end
    endtask

    task automatic test_wrap();
        do_reset();
        run_clocks(63 * 256);
        total++; if (sin1 !== 8'd116) begin bad++; $display("FAIL wrap_63 got=%0d exp=116", sin1); end
        run_clocks(256);
        total++; if (sin1 !== 8'd128) begin bad++; $display("FAIL wrap_64 got=%0d exp=128", sin1); end
        run_clocks(256);
        total++; if (sin1 !== 8'd140) begin bad++; $display("FAIL wrap_65 got=%0d exp=140", sin1); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        run_clocks(5 * 256 + 200);
        total++; if (cnt1 !== 8'd200) begin bad++; $display("FAIL mid_cnt got=%0d exp=200", cnt1); end
        total++; if (sin1 !== 8'd188) begin bad++; $display("FAIL mid_sin got=%0d exp=188", sin1); end
        reset = 1'b1;
        run_clocks(1);
        total++; if (cnt1 !== 8'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d exp=0", cnt1); end
        total++; if (sin1 !== 8'd128) begin bad++; $display("FAIL mid_rst_sin got=%0d exp=128", sin1); end
        total++; if (pwm1 !== 1'b1) begin bad++; $display("FAIL mid_rst_pwm got=%b exp=1", pwm1); end
        reset = 1'b0;
        run_clocks(255);
        total++; if (sin1 !== 8'd128) begin bad++; $display("FAIL mid_hold got=%0d exp=128", sin1); end
        total++; if (cnt1 !== 8'd255) begin bad++; $display("FAIL mid_cnt255 got=%0d exp=255", cnt1); end
        run_clocks(1);
        total++; if (sin1 !== 8'd140) begin bad++; $display("FAIL mid_restart got=%0d exp=140", sin1); end
    endtask

    task automatic test_reset_at_frame_end();
        do_reset();
        run_clocks(255);
        total++; if (cnt1 !== 8'd255) begin bad++; $display("FAIL fe_cnt got=%0d exp=255", cnt1); end
        reset = 1'b1;
        run_clocks(1);
        reset = 1'b0;
        total++; if (sin1 !== 8'd128) begin bad++; $display("FAIL fe_sin got=%0d exp=128", sin1); end
        total++; if (cnt1 !== 8'd0) begin bad++; $display("FAIL fe_cnt0 got=%0d exp=0", cnt1); end
        run_clocks(256);
        total++; if (sin1 !== 8'd140) begin bad++; $display("FAIL fe_next got=%0d exp=140", sin1); end
    endtask

    task automatic test_step4();
        logic [7:0] exp4 [16];
        exp4 = '{8'd177, 8'd218, 8'd245, 8'd255, 8'd245, 8'd218, 8'd177, 8'd128,
                 8'd79,  8'd38,  8'd11,  8'd1,   8'd11,  8'd38,  8'd79,  8'd128};
        do_reset();
        for (int f = 0; f < 16; f++) begin
            run_clocks(128);
            total++; if (sin4 !== ((f == 0) ? 8'd128 : exp4[f-1])) begin bad++; $display("FAIL step4_hold f=%0d got=%0d", f, sin4); end
            run_clocks(128);
            total++; if (sin4 !== exp4[f]) begin bad++; $display("FAIL step4 f=%0d got=%0d exp=%0d", f + 1, sin4, exp4[f]); end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_first_frame();
        test_peak();
        test_trough();
        test_wrap();
        test_mid_reset();
        test_reset_at_frame_end();
        test_step4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
